// File: rtl/addsub_pkg.sv
// Shared types and defaults for the addsub registered adder/subtractor.
// Imported by addsub and its full-adder cell.
package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } addsub_op_e;

   localparam int unsigned ADDSUB_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/addsub_fa_cell.sv
// One-bit full adder; addsub chains WIDTH of these into a ripple-carry adder.
module addsub_fa_cell
   import addsub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

// File: rtl/addsub.sv
// Registered WIDTH-bit adder/subtractor with carry/borrow-in and a one-cycle valid strobe.
// Optional macro ADDSUB_OVERFLOW_EN adds a registered signed-overflow output ovf.
module addsub
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = ADDSUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             xin,
   input  logic             op,
   output logic             out_valid,
   output logic [WIDTH-1:0] s_d,
   output logic             co_bo
`ifdef ADDSUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   addsub_op_e       op_e;
   logic             is_sub;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   logic             co_bo_next;

   // Subtract as a + ~b + ~xin so one adder serves both ops; carry-out then means "no borrow".
   always_comb begin
      op_e       = addsub_op_e'(op);
      is_sub     = (op_e == OP_SUB);
      b_x        = b ^ {WIDTH{is_sub}};
      carry[0]   = xin ^ is_sub;
      co_bo_next = carry[WIDTH] ^ is_sub;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      addsub_fa_cell u_cell (
         .a    (a[i]),
         .b    (b_x[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s_d       <= '0;
         co_bo     <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s_d   <= sum;
            co_bo <= co_bo_next;
         end
      end
   end

`ifdef ADDSUB_OVERFLOW_EN
   // Signed overflow taken from the raw adder carries, before the borrow inversion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_addsub.sv
// Directed and model-checked bench for addsub at WIDTH=4.
// Covers ovf only when ADDSUB_OVERFLOW_EN is defined.
module tb_addsub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         xin;
   logic         op;
   logic         out_valid;
   logic [W-1:0] s_d;
   logic         co_bo;
`ifdef ADDSUB_OVERFLOW_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .xin       (xin),
      .op        (op),
      .out_valid (out_valid),
      .s_d       (s_d),
      .co_bo     (co_bo)
`ifdef ADDSUB_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Apply inputs away from the edge, then return just after the capturing posedge.
   task automatic drive(input logic r, input logic v, input logic o,
                        input logic [W-1:0] aa, input logic [W-1:0] bb, input logic x);
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      op       = o;
      a        = aa;
      b        = bb;
      xin      = x;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b1);
      checks++;
      if (s_d !== 4'd0) begin
         failures++;
         $display("FAIL reset_s_d got=%0d exp=0", s_d);
      end
      checks++;
      if (co_bo !== 1'b0) begin
         failures++;
         $display("FAIL reset_co_bo got=%b exp=0", co_bo);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_add();
      logic [W-1:0] va[2] = '{4'd3, 4'd9};
      logic [W-1:0] vb[2] = '{4'd4, 4'd8};
      logic         vx[2] = '{1'b0, 1'b1};
      logic [W-1:0] es[2] = '{4'd7, 4'd2};
      logic         ec[2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, va[i], vb[i], vx[i]);
         checks++;
         if (s_d !== es[i] || co_bo !== ec[i] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_%0d got s=%0d c=%b v=%b exp s=%0d c=%b v=1",
                     i, s_d, co_bo, out_valid, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] va[2] = '{4'd9, 4'd5};
      logic [W-1:0] vb[2] = '{4'd3, 4'd7};
      logic         vx[2] = '{1'b1, 1'b0};
      logic [W-1:0] es[2] = '{4'd5, 4'd14};
      logic         ec[2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b1, va[i], vb[i], vx[i]);
         checks++;
         if (s_d !== es[i] || co_bo !== ec[i] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sub_%0d got s=%0d c=%b v=%b exp s=%0d c=%b v=1",
                     i, s_d, co_bo, out_valid, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_boundary();
      drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b1);
      checks++;
      if (s_d !== 4'd0 || co_bo !== 1'b1) begin
         failures++;
         $display("FAIL bound_sub got s=%0d c=%b exp s=0 c=1", s_d, co_bo);
      end
      drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 1'b1);
      checks++;
      if (s_d !== 4'd15 || co_bo !== 1'b1) begin
         failures++;
         $display("FAIL bound_add got s=%0d c=%b exp s=15 c=1", s_d, co_bo);
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 1'b1, 1'b0, 4'd12, 4'd6, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (s_d !== 4'd2 || co_bo !== 1'b1) begin
         failures++;
         $display("FAIL hold_data got s=%0d c=%b exp s=2 c=1", s_d, co_bo);
      end
      drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      checks++;
      if (s_d !== 4'd2 || co_bo !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_data2 got s=%0d c=%b v=%b exp s=2 c=1 v=0", s_d, co_bo, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic         vo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] va[4] = '{4'd1, 4'd1, 4'd8, 4'd6};
      logic [W-1:0] vb[4] = '{4'd2, 4'd2, 4'd8, 4'd6};
      logic         vx[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] es[4] = '{4'd3, 4'd15, 4'd0, 4'd15};
      logic         ec[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, vo[i], va[i], vb[i], vx[i]);
         checks++;
         if (s_d !== es[i] || co_bo !== ec[i] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_%0d got s=%0d c=%b v=%b exp s=%0d c=%b v=1",
                     i, s_d, co_bo, out_valid, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 1'b1, 1'b0, 4'd10, 4'd9, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 4'd10, 4'd9, 1'b1);
      checks++;
      if (s_d !== 4'd0 || co_bo !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got s=%0d c=%b v=%b exp s=0 c=0 v=0", s_d, co_bo, out_valid);
      end
   endtask

`ifdef ADDSUB_OVERFLOW_EN
   task automatic test_overflow();
      logic         vo[3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] va[3] = '{4'd7, 4'd8, 4'd2};
      logic         eo[3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, vo[i], va[i], 4'd1, 1'b0);
         checks++;
         if (ovf !== eo[i]) begin
            failures++;
            $display("FAIL ovf_%0d got=%b exp=%b", i, ovf, eo[i]);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 4'd7, 4'd1, 1'b0);
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_hold got=%b exp=0", ovf);
      end
   endtask
`endif

   // Arithmetic reference on integers; outputs hold whenever in_valid is low.
   task automatic test_random();
      logic [W-1:0] exp_s = s_d;
      logic         exp_c = co_bo;
      logic         exp_o = 1'b0;
      int           ia, ib, ix, r, sa, sb, sr;
      logic         v, o;
      for (int n = 0; n < 1000; n++) begin
         v  = ($urandom_range(0, 7) != 0);
         o  = 1'($urandom_range(0, 1));
         ia = int'($urandom_range(0, 15));
         ib = int'($urandom_range(0, 15));
         ix = int'($urandom_range(0, 1));
         sa = (ia > 7) ? ia - 16 : ia;
         sb = (ib > 7) ? ib - 16 : ib;
         if (v) begin
            if (!o) begin
               r     = ia + ib + ix;
               exp_s = 4'(r % 16);
               exp_c = (r > 15);
               sr    = sa + sb + ix;
            end else begin
               r     = ia - ib - ix + 16;
               exp_s = 4'(r % 16);
               exp_c = (ia < ib + ix);
               sr    = sa - sb - ix;
            end
            exp_o = (sr > 7) || (sr < -8);
         end
         drive(1'b1, v, o, 4'(ia), 4'(ib), ix[0]);
         checks++;
         if (s_d !== exp_s || co_bo !== exp_c || out_valid !== v) begin
            failures++;
            $display("FAIL rand_%0d got s=%0d c=%b v=%b exp s=%0d c=%b v=%b",
                     n, s_d, co_bo, out_valid, exp_s, exp_c, v);
         end
`ifdef ADDSUB_OVERFLOW_EN
         checks++;
         if (ovf !== exp_o) begin
            failures++;
            $display("FAIL rand_ovf_%0d got=%b exp=%b", n, ovf, exp_o);
         end
`endif
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      op       = 1'b0;
      a        = '0;
      b        = '0;
      xin      = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_boundary();
      test_hold();
      test_back_to_back();
      test_mid_reset();
`ifdef ADDSUB_OVERFLOW_EN
      test_overflow();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
